// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between the fetch stage (F)
// and the memory stage (M). Each access runs IDLE -> ISSUE -> WAIT -> RESP.
// The RESP cycle pulses the owner's ack, and the owner's read data register
// holds the returned word. M wins a simultaneous request because it holds
// the older instruction. A streak counter hands the port to F after
// STARVE_LIMIT consecutive M grants that were made while F was waiting.
//
// Parameters
//   LATENCY       cycles from the mem_req cycle to the mem_rdata-valid cycle (>=1)
//   STARVE_LIMIT  consecutive M grants with F waiting before F is forced (>=1)
//   AW, DW        address / data width
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   f_req, f_addr                 fetch read request (held until f_ack)
//   f_ack, f_rdata                fetch completion pulse, fetched word (held)
//   m_req, m_we, m_addr, m_wdata  memory-stage load/store request
//   m_ack, m_rdata                M completion pulse, load data (held)
//   stall_f, stall_m              req & ~ack, fed to the pipeline enables
//   mem_req, mem_we, mem_addr,
//   mem_wdata                     one-cycle access strobe to memory
//   mem_rdata                     memory read data, valid LATENCY cycles after mem_req

module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 16,
  parameter int DW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_ack,
  output logic [DW-1:0] m_rdata,
  output logic          stall_f,
  output logic          stall_m,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic            owner_m;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   streak;
  logic            any_req;
  logic            grant_m;

  assign any_req = f_req | m_req;

  // M wins unless F is also waiting and M has already used up its streak.
  assign grant_m = m_req & (~f_req | (streak < STREAK_MAX));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. The latched transaction fields already sit in registers,
  // so the memory strobe and the acks are pure state decodes.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    f_ack   = 1'b0;
    m_ack   = 1'b0;
    case (state)
      ISSUE: begin
        mem_req = 1'b1;
        mem_we  = we_q;
      end
      RESP: begin
        f_ack = ~owner_m;
        m_ack = owner_m;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_f   = f_req & ~f_ack;
  assign stall_m   = m_req & ~m_ack;

  // Transaction datapath. The grant latches everything the access needs, so
  // request inputs may change freely while the access is in flight. WAIT
  // counts down to the data-valid cycle. Stores never touch m_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_m <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      streak  <= '0;
      f_rdata <= '0;
      m_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_m <= grant_m;
            if (grant_m) begin
              addr_q  <= m_addr;
              we_q    <= m_we;
              wdata_q <= m_wdata;
              if (f_req) begin
                if (streak != STREAK_MAX) streak <= streak + 1'b1;
              end else begin
                streak <= '0;
              end
            end else begin
              addr_q  <= f_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
              streak  <= '0;
            end
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner_m) m_rdata <= mem_rdata;
              else         f_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Drives two arbiters side by side: one with LATENCY=2/STARVE_LIMIT=4 and one
// with LATENCY=1/STARVE_LIMIT=2. Each has its own memory responder and its own
// transaction-level reference model. The model works from the arbitration
// rule and the fixed timing: grant in the idle sample cycle G, mem_req in
// G+1, ack in G+LATENCY+2, and the next idle sample in G+LATENCY+3. It also
// keeps its own copy of memory contents to predict the load data.

module tb_mem_port_arbiter;

  localparam int LAT0 = 2;
  localparam int SL0  = 4;
  localparam int LAT1 = 1;
  localparam int SL1  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       f_req, f_ack, m_req, m_we, m_ack;
  logic [1:0]       stall_f, stall_m, mem_req, mem_we;
  logic [1:0][15:0] f_addr, f_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0][15:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.LATENCY(LAT0), .STARVE_LIMIT(SL0), .AW(16), .DW(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ack(f_ack[0]), .f_rdata(f_rdata[0]),
    .m_req(m_req[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_ack(m_ack[0]), .m_rdata(m_rdata[0]),
    .stall_f(stall_f[0]), .stall_m(stall_m[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.LATENCY(LAT1), .STARVE_LIMIT(SL1), .AW(16), .DW(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ack(f_ack[1]), .f_rdata(f_rdata[1]),
    .m_req(m_req[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_ack(m_ack[1]), .m_rdata(m_rdata[1]),
    .stall_f(stall_f[1]), .stall_m(stall_m[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder contents and the model's own copy of them.
  logic [15:0] env_mem   [2][256];
  logic [15:0] model_mem [2][256];
  int          pend_cyc  [2];
  logic [15:0] pend_data [2];

  // Reference model state, one transaction in flight per arbiter.
  bit          busy    [2];
  int          gcyc    [2];
  bit          own_m   [2];
  bit          t_we    [2];
  logic [15:0] t_addr  [2];
  logic [15:0] t_wdata [2];
  logic [15:0] t_rd    [2];
  int          streak  [2];
  logic [15:0] exp_fr  [2];
  logic [15:0] exp_mr  [2];
  bit          seen_fack [2];
  bit          seen_mack [2];

  // Requester behaviour knobs, in percent.
  int f_raise = 0;
  int m_raise = 0;
  int p_drop  = 100;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int slim_of(input int i);
    return (i == 0) ? SL0 : SL1;
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    busy[i]      = 1'b0;
    streak[i]    = 0;
    exp_fr[i]    = '0;
    exp_mr[i]    = '0;
    seen_fack[i] = 1'b0;
    seen_mack[i] = 1'b0;
    pend_cyc[i]  = -1;
  endtask

  // One cycle of the reference model for arbiter i, evaluated at the negedge.
  task automatic model_step(input int i);
    int k;
    int lat;
    bit e_mreq, e_fack, e_mack, gm;
    string p;
    lat    = lat_of(i);
    k      = cyc - gcyc[i];
    e_mreq = busy[i] && (k == 1);
    e_fack = busy[i] && (k == lat + 2) && !own_m[i];
    e_mack = busy[i] && (k == lat + 2) && own_m[i];
    if (e_fack) exp_fr[i] = t_rd[i];
    if (e_mack && !t_we[i]) exp_mr[i] = t_rd[i];
    p = $sformatf("u%0d c%0d", i, cyc);
    check_output({p, " mem_req"}, 16'(mem_req[i]), 16'(e_mreq));
    check_output({p, " f_ack"},   16'(f_ack[i]),   16'(e_fack));
    check_output({p, " m_ack"},   16'(m_ack[i]),   16'(e_mack));
    check_output({p, " f_rdata"}, f_rdata[i], exp_fr[i]);
    check_output({p, " m_rdata"}, m_rdata[i], exp_mr[i]);
    check_output({p, " stall_f"}, 16'(stall_f[i]), 16'(f_req[i] & ~e_fack));
    check_output({p, " stall_m"}, 16'(stall_m[i]), 16'(m_req[i] & ~e_mack));
    if (e_mreq) begin
      check_output({p, " mem_we"},   16'(mem_we[i]), 16'(t_we[i]));
      check_output({p, " mem_addr"}, mem_addr[i], t_addr[i]);
      if (t_we[i]) check_output({p, " mem_wdata"}, mem_wdata[i], t_wdata[i]);
    end
    seen_fack[i] = f_ack[i];
    seen_mack[i] = m_ack[i];
    if (busy[i] && (k == lat + 2)) begin
      busy[i] = 1'b0;
    end else if (!busy[i] && (f_req[i] || m_req[i])) begin
      gm = m_req[i] && (!f_req[i] || (streak[i] < slim_of(i)));
      if (gm) streak[i] = f_req[i] ? ((streak[i] < slim_of(i)) ? streak[i] + 1 : streak[i]) : 0;
      else    streak[i] = 0;
      own_m[i]   = gm;
      t_we[i]    = gm && m_we[i];
      t_addr[i]  = gm ? m_addr[i] : f_addr[i];
      t_wdata[i] = m_wdata[i];
      if (t_we[i]) model_mem[i][t_addr[i][7:0]] = t_wdata[i];
      else         t_rd[i] = model_mem[i][t_addr[i][7:0]];
      gcyc[i] = cyc;
      busy[i] = 1'b1;
    end
  endtask

  // Memory responder capture plus the per-cycle model check.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        model_reset(i);
      end else begin
        if (mem_req[i] === 1'b1) begin
          if (mem_we[i]) env_mem[i][mem_addr[i][7:0]] = mem_wdata[i];
          else begin
            pend_cyc[i]  = cyc + lat_of(i);
            pend_data[i] = env_mem[i][mem_addr[i][7:0]];
          end
        end
        if (chk_en) model_step(i);
      end
    end
  end

  // Advance one cycle: drive memory data and the randomised requesters just
  // after the rising edge.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      mem_rdata[i] = (cyc == pend_cyc[i]) ? pend_data[i] : 16'($urandom);
      if (f_req[i]) begin
        if (seen_fack[i]) begin
          if ($urandom_range(0, 99) < p_drop) f_req[i] = 1'b0;
          else f_addr[i] = 16'($urandom_range(0, 255));
        end
      end else if ($urandom_range(0, 99) < f_raise) begin
        f_req[i]  = 1'b1;
        f_addr[i] = 16'($urandom_range(0, 255));
      end
      if (m_req[i]) begin
        if (seen_mack[i]) begin
          if ($urandom_range(0, 99) < p_drop) m_req[i] = 1'b0;
          else begin
            m_we[i]    = ($urandom_range(0, 2) == 0);
            m_addr[i]  = 16'($urandom_range(0, 255));
            m_wdata[i] = 16'($urandom);
          end
        end
      end else if ($urandom_range(0, 99) < m_raise) begin
        m_req[i]   = 1'b1;
        m_we[i]    = ($urandom_range(0, 2) == 0);
        m_addr[i]  = 16'($urandom_range(0, 255));
        m_wdata[i] = 16'($urandom);
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) apply_stimulus();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("%s u%0d f_ack", tag, i),    16'(f_ack[i]), 16'h0);
      check_output($sformatf("%s u%0d m_ack", tag, i),    16'(m_ack[i]), 16'h0);
      check_output($sformatf("%s u%0d f_rdata", tag, i),  f_rdata[i], 16'h0);
      check_output($sformatf("%s u%0d m_rdata", tag, i),  m_rdata[i], 16'h0);
      check_output($sformatf("%s u%0d mem_req", tag, i),  16'(mem_req[i]), 16'h0);
      check_output($sformatf("%s u%0d mem_we", tag, i),   16'(mem_we[i]), 16'h0);
      check_output($sformatf("%s u%0d mem_addr", tag, i), mem_addr[i], 16'h0);
      check_output($sformatf("%s u%0d stall_f", tag, i),  16'(stall_f[i]), 16'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    f_req = '0; f_addr = '0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      gcyc[i] = 0;
      for (int a = 0; a < 256; a++) begin
        env_mem[i][a]   = 16'($urandom);
        model_mem[i][a] = env_mem[i][a];
      end
      env_mem[i][16'h0010]   = 16'hA5A5;
      model_mem[i][16'h0010] = 16'hA5A5;
    end

    #12;
    check_all_zero("reset");
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    run(2);

    // Single fetch of 0x0010 returning 0xA5A5.
    apply_stimulus();
    f_req  = 2'b11;
    f_addr = {16'h0010, 16'h0010};
    run(10);

    // Simultaneous F and M load: M first, F right after.
    apply_stimulus();
    f_req  = 2'b11;
    f_addr = {16'h0021, 16'h0021};
    m_req  = 2'b11;
    m_we   = 2'b00;
    m_addr = {16'h0200, 16'h0200};
    run(16);

    // Store of 0x1234 to 0x0300, then a load back from it.
    apply_stimulus();
    m_req   = 2'b11;
    m_we    = 2'b11;
    m_addr  = {16'h0300, 16'h0300};
    m_wdata = {16'h1234, 16'h1234};
    run(8);
    apply_stimulus();
    m_req  = 2'b11;
    m_we   = 2'b00;
    m_addr = {16'h0300, 16'h0300};
    run(8);

    // Both requesters held continuously: starvation guard.
    f_raise = 100; m_raise = 100; p_drop = 0;
    run(80);

    // Random mixed traffic.
    f_raise = 40; m_raise = 40; p_drop = 50;
    run(1500);

    // Drain, then reset while both arbiters sit in WAIT.
    f_raise = 0; m_raise = 0; p_drop = 100;
    run(20);
    apply_stimulus();
    f_req  = 2'b11;
    f_addr = {16'h0040, 16'h0040};
    run(2);
    #2 rst_n = 1'b0;
    f_req = 2'b00;
    #1;
    check_all_zero("midreset");
    run(2);
    #1 rst_n = 1'b1;
    run(3);
    apply_stimulus();
    f_req  = 2'b11;
    f_addr = {16'h0010, 16'h0010};
    run(10);

    // Back-to-back fetches.
    f_raise = 100; m_raise = 0; p_drop = 0;
    run(60);
    f_raise = 0; p_drop = 100;
    run(20);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
